bird_physics: RTL
=================

// Module: bird_physics
// PURPOSE
//  Upstream of game_controller: produces bird_y. Integrates gravity and flap impulses once per
//  frame_tick. Clamps the bird to the playfield. Takes game_state from game_controller to gate motion.
//  Outputs a registered bird_y [9:0] plus one-cycle floor/ceiling hit pulses.
// PARAMETERS
//  SCREEN_HEIGHT  480  playfield height in pixels
//  BIRD_HEIGHT    20   bird sprite height; floor limit = SCREEN_HEIGHT-BIRD_HEIGHT
//  START_Y        240  bird_y in reset and in IDLE
//  GRAVITY        1    vy increment per tick
//  FLAP_VEL       8    upward speed set by a flap (vy := -FLAP_VEL)
//  MAX_FALL       10   max downward vy (terminal velocity)
//  VW             6    signed velocity width
// PORTS
//  clk            in   1    system clock
//  reset          in   1    asynchronous, active-low reset
//  frame_tick     in   1    one-cycle pulse per video frame
//  flap_button    in   1    raw level, already synchronous to clk
//  game_state     in   2    game_pkg::state_t from game_controller
//  bird_y         out  10   top edge of bird, pixels
//  bird_vy        out  VW   signed current velocity (+ = down)
//  hit_floor      out  1    one-cycle pulse: bird clamped at floor
//  hit_ceiling    out  1    one-cycle pulse: bird clamped at y=0
// BEHAVIOUR
//  Reset (reset==0, async):
//  - bird_y=START_Y, bird_vy=0, hit_*=0, flap_pending=0, flap_prev=0.
//  Flap capture:
//  - A rising edge of flap_button (flap_prev==0 && flap_button==1) sets flap_pending, in PLAY only.
//  - A held button yields exactly one flap.
//  - flap_pending clears on the next frame_tick in PLAY, or on any state other than PLAY.
//  - Edge and frame_tick in the same cycle: the edge applies to that tick.
//  Update on a frame_tick cycle with game_state==PLAY (registered; visible the next cycle):
//  - vy_n = flap ? -FLAP_VEL : min(bird_vy+GRAVITY, MAX_FALL).
//  - y_n = bird_y + vy_n, evaluated in signed 12-bit.
//  - y_n < 0: bird_y=0, bird_vy=0, hit_ceiling=1.
//  - y_n > SCREEN_HEIGHT-BIRD_HEIGHT: bird_y=floor, bird_vy=0, hit_floor=1.
//  - Otherwise: bird_y=y_n, bird_vy=vy_n.
//  - Floor and ceiling are exclusive. hit_* are 0 on every cycle not asserted as above.
//  Other states:
//  - IDLE: bird_y=START_Y, bird_vy=0 on the next clk (a mid-flight return to IDLE snaps back).
//  - OVER: bird_y and bird_vy frozen; ticks and flaps ignored.
//  - game_state==3 (unused) behaves as OVER.
//  No motion between ticks.
// STRUCTURE
//  - game_pkg: state_t enum {IDLE=2'd0, PLAY=2'd1, OVER=2'd2}. Also SCREEN_* constants, shared
//    with game_controller.
//  - Sub-module flap_edge_detect (clk, reset, level, rise): one flop plus rise logic.
//  - Remaining logic is one always_ff for y/vy/flags plus combinational next-state.
// TESTING
//  All cases use default parameters.
//  1. Reset low mid-run -> immediately bird_y=240, bird_vy=0, hit_*=0. Hold through reset release.
//  2. PLAY, 3 ticks, no flap -> vy 1,2,3; bird_y 241,243,246; each update one cycle after its tick.
//  3. PLAY, y=246, rise flap then tick -> vy=-8, y=238. Hold the button for 5 more ticks ->
//     vy -7..-3, no re-flap.
//  4. PLAY, free fall from 240 -> vy saturates at 10; one hit_floor pulse with bird_y=460, vy=0.
//     Stays at 460 thereafter.
//  5. PLAY, y=5, flap+tick -> bird_y=0, vy=0, single hit_ceiling pulse.
//  6. OVER with ticks and flaps -> y/vy unchanged. Then IDLE -> bird_y=240 next cycle.
//     Then PLAY with a flap rise in the tick cycle -> y=232.

Source files
------------

// File: rtl/bird_physics_pkg.sv
// Shared game-level types and playfield constants for the bird datapath and its neighbours.
package bird_physics_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } state_t;

  localparam int unsigned ScreenWidth  = 640;
  localparam int unsigned ScreenHeight = 480;
  localparam int unsigned BirdHeight   = 20;
  localparam int unsigned StartY       = 240;
  localparam int unsigned Gravity      = 1;
  localparam int unsigned FlapVel      = 8;
  localparam int unsigned MaxFall      = 10;
  localparam int unsigned VelWidth     = 6;

endpackage

// File: rtl/bird_physics_if.sv
// Control inputs and position outputs of the bird physics block.
interface bird_physics_if #(
  parameter int unsigned VW = 6
);
  import bird_physics_pkg::*;

  logic                 frame_tick;
  logic                 flap_button;
  state_t               game_state;
  logic [9:0]           bird_y;
  logic signed [VW-1:0] bird_vy;
  logic                 hit_floor;
  logic                 hit_ceiling;

  modport master (
    output frame_tick, flap_button, game_state,
    input  bird_y, bird_vy, hit_floor, hit_ceiling
  );

  modport slave (
    input  frame_tick, flap_button, game_state,
    output bird_y, bird_vy, hit_floor, hit_ceiling
  );

endinterface

// File: rtl/flap_edge_detect.sv
// Rising-edge detector for the (already synchronous) flap button level.
module flap_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic rise
);

  logic prev_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= level;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/bird_physics.sv
// Per-frame gravity/flap integration of the bird's vertical position, clamped to the playfield.
module bird_physics
  import bird_physics_pkg::*;
#(
  parameter int unsigned SCREEN_HEIGHT = ScreenHeight,
  parameter int unsigned BIRD_HEIGHT   = BirdHeight,
  parameter int unsigned START_Y       = StartY,
  parameter int unsigned GRAVITY       = Gravity,
  parameter int unsigned FLAP_VEL      = FlapVel,
  parameter int unsigned MAX_FALL      = MaxFall,
  parameter int unsigned VW            = VelWidth
) (
  input logic            clk,
  input logic            reset,
  bird_physics_if.slave  bus
);

  localparam logic signed [VW:0]   GravS    = (VW+1)'(GRAVITY);
  localparam logic signed [VW:0]   MaxFallS = (VW+1)'(MAX_FALL);
  localparam logic signed [VW-1:0] FlapS    = VW'(FLAP_VEL);
  localparam logic signed [11:0]   FloorS   = 12'(SCREEN_HEIGHT - BIRD_HEIGHT);

  logic                 flap_rise;
  logic                 flap;
  logic                 flap_pending_q, flap_pending_d;
  logic [9:0]           y_q, y_d;
  logic signed [VW-1:0] vy_q, vy_d;
  logic                 hit_floor_q, hit_floor_d;
  logic                 hit_ceiling_q, hit_ceiling_d;

  logic signed [VW:0]   vy_ext, vy_inc;
  logic signed [VW-1:0] vy_fall, vy_n;
  logic signed [11:0]   y_ext, vy_12, y_n;

  flap_edge_detect u_flap_edge (
    .clk   (clk),
    .reset (reset),
    .level (bus.flap_button),
    .rise  (flap_rise)
  );

  // An edge in the tick cycle itself counts for that tick.
  assign flap = flap_pending_q | flap_rise;

  always_comb begin
    vy_ext  = {vy_q[VW-1], vy_q};
    vy_inc  = vy_ext + GravS;
    vy_fall = (vy_inc > MaxFallS) ? MaxFallS[VW-1:0] : vy_inc[VW-1:0];
    vy_n    = flap ? -FlapS : vy_fall;
    y_ext   = {2'b00, y_q};
    vy_12   = 12'(vy_n);
    y_n     = y_ext + vy_12;
  end

  always_comb begin
    y_d            = y_q;
    vy_d           = vy_q;
    hit_floor_d    = 1'b0;
    hit_ceiling_d  = 1'b0;
    flap_pending_d = 1'b0;
    unique case (bus.game_state)
      IDLE: begin
        y_d  = 10'(START_Y);
        vy_d = '0;
      end
      PLAY: begin
        if (bus.frame_tick) begin
          if (y_n < 12'sd0) begin
            y_d           = '0;
            vy_d          = '0;
            hit_ceiling_d = 1'b1;
          end else if (y_n > FloorS) begin
            y_d         = FloorS[9:0];
            vy_d        = '0;
            hit_floor_d = 1'b1;
          end else begin
            y_d  = y_n[9:0];
            vy_d = vy_n;
          end
        end else begin
          flap_pending_d = flap;
        end
      end
      // OVER and the unused encoding freeze the bird.
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      y_q            <= 10'(START_Y);
      vy_q           <= '0;
      hit_floor_q    <= 1'b0;
      hit_ceiling_q  <= 1'b0;
      flap_pending_q <= 1'b0;
    end else begin
      y_q            <= y_d;
      vy_q           <= vy_d;
      hit_floor_q    <= hit_floor_d;
      hit_ceiling_q  <= hit_ceiling_d;
      flap_pending_q <= flap_pending_d;
    end
  end

  assign bus.bird_y      = y_q;
  assign bus.bird_vy     = vy_q;
  assign bus.hit_floor   = hit_floor_q;
  assign bus.hit_ceiling = hit_ceiling_q;

endmodule
